// File: rtl/tickgen_pkg.sv
// Shared constants and helpers for the tick generator.
// Board half-periods assume a 100 MHz src_clk.
package tickgen_pkg;

    localparam int CNT_W_DEF = 26;

    localparam int HALF_1HZ  = 50_000_000;
    localparam int HALF_2HZ  = 25_000_000;
    localparam int HALF_4HZ  = 12_500_000;
    localparam int HALF_50HZ = 1_000_000;

    // A half-period of 0 would never wrap; treat it as 1 (toggle every cycle).
    function automatic logic [63:0] clamp_half(input logic [63:0] h);
        return (h == 64'd0) ? 64'd1 : h;
    endfunction

endpackage

// File: rtl/tickgen_channel.sv
// One divider channel: counter, active/pending half-period, tick and square wave.
// Pending-load registers exist only with TICKGEN_RUNTIME_CFG_EN defined.
module tickgen_channel
    import tickgen_pkg::*;
#(
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF   = CNT_W'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             sync_clr_i,
`ifdef TICKGEN_RUNTIME_CFG_EN
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    output logic             pend_o,
`endif
    output logic             tick_o,
    output logic             clk_o
);

    localparam logic [CNT_W-1:0] DEF_C = CNT_W'(clamp_half(64'(DEF)));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half;
    logic             wrap;

`ifdef TICKGEN_RUNTIME_CFG_EN
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    assign half   = half_q;
    assign pend_o = pend_q;
`else
    assign half = DEF_C;
`endif

    assign wrap = (cnt_q == half - CNT_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
`ifdef TICKGEN_RUNTIME_CFG_EN
        half_d = half_q;
        pval_d = pval_q;
        pend_d = pend_q;
`endif
        if (sync_clr_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
`ifdef TICKGEN_RUNTIME_CFG_EN
            // A load is only accepted with pend clear, so these never collide.
            if (ld_i)        half_d = ld_val_i;
            else if (pend_q) half_d = pval_q;
            pend_d = 1'b0;
`endif
        end else if (run_i) begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
`ifdef TICKGEN_RUNTIME_CFG_EN
                if (pend_q) begin
                    half_d = pval_q;
                    pend_d = 1'b0;
                end
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef TICKGEN_RUNTIME_CFG_EN
        if (ld_i && !sync_clr_i) begin
            pend_d = 1'b1;
            pval_d = ld_val_i;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef TICKGEN_RUNTIME_CFG_EN
            half_q <= DEF_C;
            pval_q <= '0;
            pend_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
`ifdef TICKGEN_RUNTIME_CFG_EN
            half_q <= half_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
`endif
        end
    end

    assign tick_o = tick_q;
    assign clk_o  = clk_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick / square-wave divider with optional runtime half-period loads.
// Runtime configuration is compiled in with TICKGEN_RUNTIME_CFG_EN.
module tick_generator
    import tickgen_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {NUM_CH{CNT_W'(1)}},
    localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              src_clk,
    input  logic              reset,
    input  logic              run,
    input  logic              sync_clr,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

`ifdef TICKGEN_RUNTIME_CFG_EN
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ld;
    logic [CNT_W-1:0]  ld_val;

    assign ld_val = CNT_W'(clamp_half(64'(cfg_half)));

    // Out-of-range channels report ready and match no ld bit, so the load drops.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i)) cfg_ready = !pend[i];
    end

    always_comb begin
        ld = '0;
        for (int i = 0; i < NUM_CH; i++)
            ld[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_valid, cfg_ch, cfg_half};
    assign cfg_ready  = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tickgen_channel #(
            .CNT_W (CNT_W),
            .DEF   (DEF_HALF[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i      (src_clk),
            .rst_ni     (reset),
            .run_i      (run),
            .sync_clr_i (sync_clr),
`ifdef TICKGEN_RUNTIME_CFG_EN
            .ld_i       (ld[g]),
            .ld_val_i   (ld_val),
            .pend_o     (pend[g]),
`endif
            .tick_o     (tick[g]),
            .clk_o      (clk_out[g])
        );
    end

endmodule
